// File: rtl/mem_responder.sv
// mem_responder: word-addressed read responder. Requests flow through a
// two-stage read pipeline (S1 address register, S2 synchronous memory read)
// into a first-word-fall-through response FIFO. An independent loader port
// writes the backing memory.
// Optional build macro MEM_RSP_ADDR_CHECK_EN: out-of-range reads return 0 and
// raise a sticky err output. Without it, out-of-range reads alias onto the
// low address bits and the err port does not exist.

package constants_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
endpackage

module mem_responder #(
  parameter int ADDR_WIDTH = constants_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req_vld,
  output logic                  m_req_rdy,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  output logic                  m_rsp_vld,
  input  logic                  m_rsp_rdy,
  output logic [DATA_WIDTH-1:0] m_rsp_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
`ifdef MEM_RSP_ADDR_CHECK_EN
  , output logic                err
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [OCC_W-1:0]    OCC_MAX   = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]    OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W:0]      PTR_ONE   = (PTR_W + 1)'(1);

  // Backing storage: deliberately not reset.
  logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

  logic                  r_s1_vld;
  logic [IDX_W-1:0]      r_s1_idx;
  logic                  r_s2_vld;
  logic [DATA_WIDTH-1:0] r_s2_data;

  // FIFO pointers carry one extra wrap bit so full and empty are distinct.
  logic [DATA_WIDTH-1:0] r_fifo [0:FIFO_DEPTH-1];
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;

  logic w_req_acc;
  logic w_pop;
  logic w_empty;
  logic w_wr_ok;

  // occ covers S1 + S2 + FIFO, so gating accepts on it alone keeps the FIFO
  // from ever overflowing.
  assign m_req_rdy  = (r_occ < OCC_MAX);
  assign w_req_acc  = m_req_vld && m_req_rdy;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign m_rsp_vld  = !w_empty;
  assign w_pop      = m_rsp_vld && m_rsp_rdy;
  assign m_rsp_data = r_fifo[r_rd_ptr[PTR_W-1:0]];
  assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < MEM_LIMIT);

`ifdef MEM_RSP_ADDR_CHECK_EN
  logic w_req_oor;
  logic r_s1_oor;
  logic r_err;

  assign w_req_oor = ({1'b0, m_req_addr} >= MEM_LIMIT);
  assign err       = r_err;

  // Sticky error flag, raised on the edge an out-of-range request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_req_acc && w_req_oor) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end
`else
  // Upper request-address bits are intentionally ignored (modulo aliasing).
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^m_req_addr[ADDR_WIDTH-1:IDX_W];
`endif

  // Loader write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // S1/S2 valid bits; cleared by reset so in-flight requests are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_req_acc;
      r_s2_vld <= r_s1_vld;
    end
  end

  // S1 address capture, loaded only when a request is accepted.
  always_ff @(posedge clk) begin
    if (w_req_acc) begin
      r_s1_idx <= m_req_addr[IDX_W-1:0];
`ifdef MEM_RSP_ADDR_CHECK_EN
      r_s1_oor <= w_req_oor;
`endif
    end
  end

  // S2 synchronous read; a same-edge loader write is not seen (old data wins).
  always_ff @(posedge clk) begin
    if (r_s1_vld) begin
`ifdef MEM_RSP_ADDR_CHECK_EN
      r_s2_data <= r_s1_oor ? '0 : r_mem[r_s1_idx];
`else
      r_s2_data <= r_mem[r_s1_idx];
`endif
    end
  end

  // FIFO push side; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (r_s2_vld) begin
      r_fifo[r_wr_ptr[PTR_W-1:0]] <= r_s2_data;
      r_wr_ptr                    <= r_wr_ptr + PTR_ONE;
    end
  end

  // FIFO pop side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Outstanding counter: accept and pop on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_req_acc, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model (memory
// array, pipeline queue, response queue, outstanding count) is compared with
// the DUT every cycle, plus directed scenarios with literal expectations.

module tb_mem_responder;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MD = 256;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_req_vld = 1'b0;
  logic          m_req_rdy;
  logic [AW-1:0] m_req_addr = 16'd0;
  logic          m_rsp_vld;
  logic          m_rsp_rdy = 1'b0;
  logic [DW-1:0] m_rsp_data;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = 16'd0;
  logic [DW-1:0] wr_data = 32'd0;
`ifdef MEM_RSP_ADDR_CHECK_EN
  logic          err;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef MEM_RSP_ADDR_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stage;
  } pend_t;

  logic [DW-1:0] mdl_mem [MD];
  pend_t         pend[$];
  logic [DW-1:0] vis[$];
  int            m_occ = 0;
  logic          m_err = 1'b0;

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
`ifdef MEM_RSP_ADDR_CHECK_EN
    if (a >= 16'd256) return 32'h0;
`endif
    return mdl_mem[a[7:0]];
  endfunction

  initial begin
    forever begin
      bit    acc;
      bit    pop;
      pend_t p;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        vis.delete();
        m_occ = 0;
        m_err = 1'b0;
      end else begin
        acc = m_req_vld && (m_occ < FD);
        pop = (vis.size() != 0) && m_rsp_rdy;
        if (pop) void'(vis.pop_front());
        while (pend.size() != 0 && pend[0].stage == 2) begin
          p = pend.pop_front();
          vis.push_back(p.data);
        end
        foreach (pend[k]) begin
          if (pend[k].stage == 1) begin
            pend[k].data  = mdl_read(pend[k].addr);
            pend[k].stage = 2;
          end
        end
        if (wr_en && wr_addr < 16'd256) mdl_mem[wr_addr[7:0]] = wr_data;
        if (acc) begin
          p.addr = m_req_addr; p.data = 32'h0; p.stage = 1;
          pend.push_back(p);
          if (m_req_addr >= 16'd256) m_err = 1'b1;
        end
        m_occ = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_vld", 32'(m_rsp_vld), 32'd0);
        chk("rst_rdy", 32'(m_req_rdy), 32'd1);
        chk("rst_data", m_rsp_data, 32'd0);
`ifdef MEM_RSP_ADDR_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
      end else begin
        chk("cyc_rdy", 32'(m_req_rdy), 32'(m_occ < FD));
        chk("cyc_vld", 32'(m_rsp_vld), 32'(vis.size() != 0));
        if (vis.size() != 0) chk("cyc_data", m_rsp_data, vis[0]);
`ifdef MEM_RSP_ADDR_CHECK_EN
        chk("cyc_err", 32'(err), 32'(m_err));
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Single request with m_rsp_rdy=1; data checked in the cycle after accept+2.
  task automatic read_one(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    m_rsp_rdy = 1'b1;
    m_req_vld = 1'b1; m_req_addr = a;
    @(negedge clk);
    m_req_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_vld"}, 32'(m_rsp_vld), 32'd1);
    chk(nm, m_rsp_data, exp);
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("reset_vld", 32'(m_rsp_vld), 32'd0);
    chk("reset_rdy", 32'(m_req_rdy), 32'd1);
    chk("reset_data", m_rsp_data, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // preload the whole memory with 0x100+i, then the 0..3 pattern
    for (int i = 0; i < MD; i++) wr(16'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) wr(16'(i), 32'hA0 + 32'(i));

    // back-to-back reads of 0..3
    m_rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) chk("lat_not_early", 32'(m_rsp_vld), 32'd0);
      if (i >= 3 && i < 7) begin
        chk("b2b_vld", 32'(m_rsp_vld), 32'd1);
        chk("b2b_data", m_rsp_data, 32'hA0 + 32'(i - 3));
      end
      m_req_vld  = (i < 4);
      m_req_addr = 16'(i);
    end
    m_req_vld = 1'b0;
    @(negedge clk);

    // backpressure: continuous requests with m_rsp_rdy low
    m_rsp_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      m_req_vld = 1'b1; m_req_addr = 16'd10 + 16'(acc);
      if (m_req_rdy) acc++;
      @(negedge clk);
    end
    chk("bp_accepts", acc, 32'd4);
    chk("bp_rdy_low", 32'(m_req_rdy), 32'd0);
    chk("bp_head", m_rsp_data, 32'h10A);
    @(negedge clk);
    chk("bp_head_held", m_rsp_data, 32'h10A);
    m_req_vld = 1'b0;
    m_rsp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain", m_rsp_data, 32'h10A + 32'(k));
      @(negedge clk);
    end
    chk("bp_empty", 32'(m_rsp_vld), 32'd0);
    chk("bp_rdy_back", 32'(m_req_rdy), 32'd1);

    // fill to 4, then stream with accept+pop at occ=3
    m_rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_req_vld = 1'b1; m_req_addr = 16'd20 + 16'(i);
      @(negedge clk);
    end
    m_req_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_rdy_low", 32'(m_req_rdy), 32'd0);
    m_rsp_rdy = 1'b1; m_req_vld = 1'b1; m_req_addr = 16'd24;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("occ3_rdy", 32'(m_req_rdy), 32'd1);
      chk("stream_data", m_rsp_data, 32'h114 + 32'(j));
      m_req_addr = 16'd24 + 16'(j - 1);
    end
    m_req_vld = 1'b0;
    repeat (8) @(negedge clk);
    chk("stream_empty", 32'(m_rsp_vld), 32'd0);

    // read/write collision on addr 5
    wr(16'd5, 32'h11);
    m_req_vld = 1'b1; m_req_addr = 16'd5;
    @(negedge clk);
    m_req_vld = 1'b0;
    wr_en = 1'b1; wr_addr = 16'd5; wr_data = 32'h22;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("coll_vld", 32'(m_rsp_vld), 32'd1);
    chk("coll_old", m_rsp_data, 32'h11);
    @(negedge clk);
    read_one(16'd5, 32'h22, "coll_new");

    // out-of-range write (aliases to 5) must be dropped
    wr(16'd261, 32'hDEAD);
    read_one(16'd5, 32'h22, "oor_wr_ignored");

    // reset with 3 requests outstanding
    m_rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_req_vld = 1'b1; m_req_addr = 16'd7 + 16'(i);
      @(negedge clk);
    end
    m_req_vld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_vld", 32'(m_rsp_vld), 32'd0);
    chk("midrst_rdy", 32'(m_req_rdy), 32'd1);
    chk("midrst_data", m_rsp_data, 32'd0);
    #2 rst_n = 1'b1;
    m_rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(m_rsp_vld), 32'd0);
    end
    read_one(16'd1, 32'hA1, "post_rst_read");

    // out-of-range request to MEM_DEPTH+2
    wr(16'd2, 32'h77);
`ifdef MEM_RSP_ADDR_CHECK_EN
    chk("err_before", 32'(err), 32'd0);
    read_one(16'd258, 32'h0, "oor_read");
    chk("err_after", 32'(err), 32'd1);
`else
    read_one(16'd258, 32'h77, "oor_read");
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
